// File: rtl/mem_access_pkg.sv
// Shared definitions for mem_access_unit: access size codes, FSM state encoding and
// request legality / address alignment helpers.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_WAIT    = 3'd1,
    ST_WR_ASSERT  = 3'd2,
    ST_WR_RELEASE = 3'd3,
    ST_RESP       = 3'd4
  } mau_state_e;

  // A request is rejected when its size code is illegal or its address is not naturally aligned.
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Little-endian lane handling: extract+extend a sub-word from a read word for loads,
// and replace only the addressed lane of a read word for sub-word stores.
module mem_lane_merge
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and extension / merge for the current request size.
  always_comb begin
    byte_s      = 8'h00;
    half_s      = 16'h0000;
    load_data   = 32'h0000_0000;
    merged_word = word;
    case (lane)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (lane[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (size)
      SZ_BYTE: begin
        load_data = {{24{is_signed & byte_s[7]}}, byte_s};
        case (lane)
          2'd0:    merged_word[7:0]   = wdata[7:0];
          2'd1:    merged_word[15:8]  = wdata[7:0];
          2'd2:    merged_word[23:16] = wdata[7:0];
          2'd3:    merged_word[31:24] = wdata[7:0];
          default: merged_word        = word;
        endcase
      end
      SZ_HALF: begin
        load_data = {{16{is_signed & half_s[15]}}, half_s};
        if (lane[1]) begin
          merged_word[31:16] = wdata[15:0];
        end else begin
          merged_word[15:0] = wdata[15:0];
        end
      end
      SZ_WORD: begin
        load_data   = word;
        merged_word = wdata;
      end
      default: begin
        load_data   = 32'h0000_0000;
        merged_word = word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side initiator for phy_mem_ctrl: aligned word accesses, read-modify-write for sub-word
// stores, single-cycle is_write pulses. Optional busy timeout with MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int READ_SETTLE    = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk50M,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        phy_is_write,
  output logic [31:0] phy_addr,
  output logic [31:0] phy_wdata,
  input  logic [31:0] phy_rdata,
  input  logic        phy_busy
);

  // One extra hold cycle covers the registered address launch before the settle window starts.
  localparam int SETTLE_LIMIT = READ_SETTLE + 1;
  localparam int SCW          = $clog2(SETTLE_LIMIT + 1);
  localparam logic [SCW-1:0] SETTLE_MAX = SCW'(SETTLE_LIMIT);

  mau_state_e     state_r;
  logic [SCW-1:0] settle_cnt_r;
  logic           req_ready_r;
  logic           resp_valid_r;
  logic           resp_err_r;
  logic [31:0]    resp_rdata_r;
  logic           phy_is_write_r;
  logic [31:0]    phy_addr_r;
  logic [31:0]    phy_wdata_r;
  logic           write_r;
  logic [1:0]     size_r;
  logic           signed_r;
  logic [1:0]     lane_r;
  logic [31:0]    wdata_q_r;
  logic [31:0]    load_s;
  logic [31:0]    merged_s;
  logic           waiting_s;
  logic           timeout_s;

  assign req_ready    = req_ready_r;
  assign resp_valid   = resp_valid_r;
  assign resp_err     = resp_err_r;
  assign resp_rdata   = resp_rdata_r;
  assign phy_is_write = phy_is_write_r;
  assign phy_addr     = phy_addr_r;
  assign phy_wdata    = phy_wdata_r;

  assign waiting_s = (state_r == ST_RD_WAIT) || (state_r == ST_WR_ASSERT) ||
                     (state_r == ST_WR_RELEASE);

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt_r;

  assign timeout_s = waiting_s && phy_busy && (to_cnt_r == TO_LAST);

  // Consecutive-busy counter; any idle-bus cycle or leaving the wait states clears it.
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      to_cnt_r <= '0;
    end else if (waiting_s && phy_busy) begin
      to_cnt_r <= to_cnt_r + TW'(1);
    end else begin
      to_cnt_r <= '0;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  mem_lane_merge u_lane_merge (
    .size        (size_r),
    .is_signed   (signed_r),
    .lane        (lane_r),
    .word        (phy_rdata),
    .wdata       (wdata_q_r),
    .load_data   (load_s),
    .merged_word (merged_s)
  );

  // Access sequencer; every bus-facing and response output is a register of this block.
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      settle_cnt_r   <= '0;
      req_ready_r    <= 1'b1;
      resp_valid_r   <= 1'b0;
      resp_err_r     <= 1'b0;
      resp_rdata_r   <= 32'h0000_0000;
      phy_is_write_r <= 1'b0;
      phy_addr_r     <= 32'h0000_0000;
      phy_wdata_r    <= 32'h0000_0000;
      write_r        <= 1'b0;
      size_r         <= SZ_BYTE;
      signed_r       <= 1'b0;
      lane_r         <= 2'b00;
      wdata_q_r      <= 32'h0000_0000;
    end else begin
      resp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            write_r      <= req_write;
            size_r       <= req_size;
            signed_r     <= req_signed;
            lane_r       <= req_addr[1:0];
            wdata_q_r    <= req_wdata;
            req_ready_r  <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
            settle_cnt_r <= '0;
            if (req_bad(req_size, req_addr[1:0])) begin
              // Rejected requests never touch the bus.
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              state_r      <= ST_RESP;
            end else if (!req_write || (req_size != SZ_WORD)) begin
              phy_addr_r <= word_align(req_addr);
              state_r    <= ST_RD_WAIT;
            end else begin
              phy_addr_r  <= word_align(req_addr);
              phy_wdata_r <= req_wdata;
              state_r     <= ST_WR_ASSERT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (timeout_s) begin
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
            state_r      <= ST_RESP;
          end else if (settle_cnt_r < SETTLE_MAX) begin
            settle_cnt_r <= settle_cnt_r + SCW'(1);
          end else if (!phy_busy) begin
            if (write_r) begin
              phy_wdata_r <= merged_s;
              state_r     <= ST_WR_ASSERT;
            end else begin
              resp_rdata_r <= load_s;
              resp_valid_r <= 1'b1;
              state_r      <= ST_RESP;
            end
          end
        end
        ST_WR_ASSERT: begin
          if (phy_is_write_r) begin
            phy_is_write_r <= 1'b0;
            state_r        <= ST_WR_RELEASE;
          end else if (timeout_s) begin
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
            state_r      <= ST_RESP;
          end else if (!phy_busy) begin
            phy_is_write_r <= 1'b1;
          end
        end
        ST_WR_RELEASE: begin
          phy_is_write_r <= 1'b0;
          if (timeout_s) begin
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
            state_r      <= ST_RESP;
          end else if (!phy_busy) begin
            resp_valid_r <= 1'b1;
            state_r      <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Park the bus on address 0 so no side-effect register is ever read while idle.
          phy_is_write_r <= 1'b0;
          phy_addr_r     <= 32'h0000_0000;
          phy_wdata_r    <= 32'h0000_0000;
          resp_err_r     <= 1'b0;
          resp_rdata_r   <= 32'h0000_0000;
          req_ready_r    <= 1'b1;
          state_r        <= ST_IDLE;
        end
        default: begin
          phy_is_write_r <= 1'b0;
          phy_addr_r     <= 32'h0000_0000;
          phy_wdata_r    <= 32'h0000_0000;
          resp_err_r     <= 1'b0;
          resp_rdata_r   <= 32'h0000_0000;
          req_ready_r    <= 1'b1;
          state_r        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural phy_mem_ctrl (16-word memory,
// busy after each is_write rising edge). Timeout case runs when MEM_ACCESS_TIMEOUT_EN is defined.
module tb_mem_access_unit;

  logic        clk50M = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        phy_is_write;
  logic [31:0] phy_addr;
  logic [31:0] phy_wdata;
  logic [31:0] phy_rdata;
  logic        phy_busy;

  mem_access_unit #(.READ_SETTLE(1), .TIMEOUT_CYCLES(64)) dut (
    .clk50M       (clk50M),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .phy_is_write (phy_is_write),
    .phy_addr     (phy_addr),
    .phy_wdata    (phy_wdata),
    .phy_rdata    (phy_rdata),
    .phy_busy     (phy_busy)
  );

  always #10 clk50M = ~clk50M;

  // ---------------- phy_mem_ctrl model ----------------
  logic [31:0] mem [16];
  logic        prev_wr = 1'b0;
  int          busy_cnt = 0;
  int          wr_busy_len;
  logic        stuck_busy;
  logic        pre_en;
  logic [3:0]  pre_idx;
  logic [31:0] pre_val;

  assign phy_rdata = mem[phy_addr[5:2]];
  assign phy_busy  = (busy_cnt != 0) || stuck_busy;

  always @(posedge clk50M) begin
    prev_wr <= phy_is_write;
    if (pre_en) mem[pre_idx] <= pre_val;
    if (phy_is_write && !prev_wr) begin
      mem[phy_addr[5:2]] <= phy_wdata;
      busy_cnt <= wr_busy_len;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          writes;
    logic [31:0] wdata;
    int          exact_lat;
    int          min_lat;
    logic        no_bus;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rst_chk_seq = 0;
  int   rst_chk_done = 0;
  int   tmo_seq = 0;
  int   tmo_done = 0;

  always @(posedge clk50M) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks = checks + 1;
    if (act !== exp_v) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp_v);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  int          acc_cyc = 0;
  int          pulses = 0;
  logic        dbl = 1'b0;
  logic        touched = 1'b0;
  logic        mon_prev_wr = 1'b0;
  logic [31:0] last_wdata = 32'h0;
  logic        idle_armed = 1'b0;

  always @(negedge clk50M) begin
    exp_t e;
    int   lat;
    if (tmo_seq != tmo_done) begin
      chk("wait_bound", 32'h0, 32'h1);
      tmo_done = tmo_seq;
    end
    if (!rst) begin
      if (rst_chk_seq != rst_chk_done) begin
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_phy_is_write", {31'h0, phy_is_write}, 32'h0);
        chk("rst_phy_addr", phy_addr, 32'h0);
        chk("rst_phy_wdata", phy_wdata, 32'h0);
        rst_chk_done = rst_chk_seq;
      end
      mon_prev_wr = 1'b0;
    end else begin
      if (phy_is_write && mon_prev_wr) dbl = 1'b1;
      if (phy_is_write && !mon_prev_wr) begin
        pulses = pulses + 1;
        last_wdata = phy_wdata;
      end
      mon_prev_wr = phy_is_write;
      if (phy_addr != 32'h0) touched = 1'b1;
      if (req_valid && req_ready) begin
        acc_cyc = cyc + 1;
        pulses = 0;
        dbl = 1'b0;
        touched = 1'b0;
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          lat = cyc - acc_cyc;
          chk({e.name, "_rdata"}, resp_rdata, e.rdata);
          chk({e.name, "_err"}, {31'h0, resp_err}, {31'h0, e.err});
          chk({e.name, "_writes"}, dbl ? 32'd99 : pulses, e.writes);
          if (e.writes > 0) chk({e.name, "_wdata"}, last_wdata, e.wdata);
          if (e.exact_lat > 0) chk({e.name, "_latency"}, lat, e.exact_lat);
          if (e.min_lat > 0) chk({e.name, "_after_busy"}, {31'h0, lat >= e.min_lat}, 32'h1);
          if (e.no_bus) chk({e.name, "_no_bus"}, {31'h0, touched}, 32'h0);
        end
        idle_armed = 1'b1;
      end else if (idle_armed && req_ready) begin
        chk("idle_bus", {phy_is_write, phy_addr[30:0]}, 32'h0);
        chk("idle_addr_msb", {31'h0, phy_addr[31]}, 32'h0);
        idle_armed = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_en  = 1'b1;
    @(posedge clk50M);
    #1 pre_en = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk50M);
      #1;
      if (req_ready) break;
    end
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk50M);
    #1 req_valid = 1'b0;
  endtask

  task automatic req(input string nm, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] erd,
                     input logic eerr, input int ewr, input logic [31:0] ewd,
                     input int elat, input int emin, input logic enobus);
    exp_t e;
    e.name = nm; e.rdata = erd; e.err = eerr; e.writes = ewr; e.wdata = ewd;
    e.exact_lat = elat; e.min_lat = emin; e.no_bus = enobus;
    sb.push_back(e);
    issue(w, sz, sg, a, wd);
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk50M);
    end
    if (sb.size() != 0) begin
      tmo_seq = tmo_seq + 1;
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    stuck_busy = 1'b0; wr_busy_len = 2;
    pre_en = 1'b0; pre_idx = 4'd0; pre_val = 32'h0;
    rst_chk_seq = 1;
    preload(4'd0, 32'hDEAD_BEEF);
    preload(4'd1, 32'h5566_7788);
    preload(4'd14, 32'h0000_0000);
    @(posedge clk50M);
    #1 rst = 1'b1;

    //   name        w     sz    sg    addr          wdata         exp_rdata     err  wr ewdata        lat min nobus
    req("lw",        1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 0, 32'h0,         3, 0, 1'b0);
    preload(4'd0, 32'h8011_2233);
    req("lb_s3",     1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,        32'hFFFF_FF80, 1'b0, 0, 32'h0,         3, 0, 1'b0);
    req("lbu_3",     1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,        32'h0000_0080, 1'b0, 0, 32'h0,         3, 0, 1'b0);
    req("lh_s1",     1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0,        32'hFFFF_8011, 1'b0, 0, 32'h0,         3, 0, 1'b0);
    req("lhu_1",     1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0,        32'h0000_8011, 1'b0, 0, 32'h0,         3, 0, 1'b0);
    req("lb_s0",     1'b0, 2'd0, 1'b1, 32'h0000_0100, 32'h0,        32'h0000_0033, 1'b0, 0, 32'h0,         3, 0, 1'b0);
    req("lh_s0",     1'b0, 2'd1, 1'b1, 32'h0000_0100, 32'h0,        32'h0000_2233, 1'b0, 0, 32'h0,         3, 0, 1'b0);
    preload(4'd0, 32'h1122_3344);
    req("sb_1",      1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_00AB, 32'h0,        1'b0, 1, 32'h1122_AB44, 0, 0, 1'b0);
    req("rb_sb",     1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,        32'h1122_AB44, 1'b0, 0, 32'h0,         3, 0, 1'b0);
    req("sh_1",      1'b1, 2'd1, 1'b0, 32'h0000_0106, 32'h1234_BEEF, 32'h0,        1'b0, 1, 32'hBEEF_7788, 0, 0, 1'b0);
    req("sb_0",      1'b1, 2'd0, 1'b0, 32'h0000_0104, 32'hFFFF_FF01, 32'h0,        1'b0, 1, 32'hBEEF_7701, 0, 0, 1'b0);
    req("rb_sh",     1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0,        32'hBEEF_7701, 1'b0, 0, 32'h0,         3, 0, 1'b0);
    req("lbu_7",     1'b0, 2'd0, 1'b0, 32'h0000_0107, 32'h0,        32'h0000_00BE, 1'b0, 0, 32'h0,         3, 0, 1'b0);
    wr_busy_len = 5;
    req("sw_busy",   1'b1, 2'd2, 1'b0, 32'h1FD0_03F8, 32'h0000_0041, 32'h0,        1'b0, 1, 32'h0000_0041, 0, 7, 1'b0);
    wr_busy_len = 2;
    req("rb_sw",     1'b0, 2'd2, 1'b0, 32'h1FD0_03F8, 32'h0,        32'h0000_0041, 1'b0, 0, 32'h0,         3, 0, 1'b0);
    req("lw_mis",    1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0,        32'h0,         1'b1, 0, 32'h0,         0, 0, 1'b1);
    req("sz3",       1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0,        32'h0,         1'b1, 0, 32'h0,         0, 0, 1'b1);
    req("sh_mis",    1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'h0000_FFFF, 32'h0,        1'b1, 0, 32'h0,         0, 0, 1'b1);
    req("sw_mis",    1'b1, 2'd2, 1'b0, 32'h1FD0_03F9, 32'h0000_0001, 32'h0,        1'b1, 0, 32'h0,         0, 0, 1'b1);
`ifdef MEM_ACCESS_TIMEOUT_EN
    stuck_busy = 1'b1;
    req("lw_tmo",    1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,        32'h0,         1'b1, 0, 32'h0,        64, 0, 1'b0);
    stuck_busy = 1'b0;
`endif

    // Reset while the unit sits in WR_RELEASE; the controller still completes its write.
    wr_busy_len = 20;
    issue(1'b1, 2'd2, 1'b0, 32'h1FD0_03F8, 32'h5A5A_0001);
    for (int i = 0; i < 50; i++) begin
      if (phy_busy) break;
      @(posedge clk50M);
      #1;
    end
    @(posedge clk50M);
    #1 rst = 1'b0;
    rst_chk_seq = rst_chk_seq + 1;
    repeat (2) @(posedge clk50M);
    #1 rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!phy_busy) break;
      @(posedge clk50M);
      #1;
    end
    wr_busy_len = 2;
    req("rb_rst",    1'b0, 2'd2, 1'b0, 32'h1FD0_03F8, 32'h0,        32'h5A5A_0001, 1'b0, 0, 32'h0,         3, 0, 1'b0);

    repeat (3) @(negedge clk50M);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
